// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Bus types and the bundled handshake interface for the two-to-one memory arbiter.
//   ireq/iresp : instruction side of the core (request in, response out)
//   dreq/dresp : data side of the core (request in, response out)
//   mreq/mresp : shared memory port (request out, response in)
// Modports:
//   slave  : the arbiter's view (core requests and memory responses are inputs)
//   master : the surrounding system's view (core plus memory model)

package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  mreq;
    dbus_resp_t mresp;

    modport slave  (input  ireq, dreq, mresp, output iresp, dresp, mreq);
    modport master (output ireq, dreq, mresp, input  iresp, dresp, mreq);
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Grants the single shared memory port to either the instruction or the data
// side of the core, one transaction at a time, with absolute data priority.
// Instruction fetches are converted into word-sized data-bus reads.
// Ports:
//   clk   : core clock, state changes on the rising edge
//   reset : asynchronous active-high reset, forces IDLE and silences all outputs
//   bus   : mem_bus_arbiter_if.slave carrying ireq/iresp, dreq/dresp, mreq/mresp

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR_I = 3'd1;
    localparam logic [2:0] S_ADDR_D = 3'd2;
    localparam logic [2:0] S_DATA_I = 3'd3;
    localparam logic [2:0] S_DATA_D = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic       w_grantI;
    logic       w_grantD;
    logic       w_addrPhase;
    logic       w_issue;

    // Grant is chosen only in IDLE; once a side is issued it stays locked until
    // its transaction completes. Reset masks the grant so outputs go quiet at once.
    always_comb begin
        w_grantI = 1'b0;
        w_grantD = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    w_grantD = bus.dreq.valid;
                    w_grantI = !bus.dreq.valid && bus.ireq.valid;
                end
                S_ADDR_D, S_DATA_D: w_grantD = 1'b1;
                S_ADDR_I, S_DATA_I: w_grantI = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_addrPhase = (r_state == S_IDLE) || (r_state == S_ADDR_I) || (r_state == S_ADDR_D);
    assign w_issue     = w_addrPhase && (w_grantI || w_grantD);

    // Memory request: data side passes through, instruction side becomes a word read.
    always_comb begin
        bus.mreq = '0;
        if (w_issue && w_grantD) begin
            bus.mreq = bus.dreq;
        end else if (w_issue && w_grantI) begin
            bus.mreq.valid = 1'b1;
            bus.mreq.addr  = bus.ireq.addr;
            bus.mreq.size  = MSIZE4;
        end
    end

    // Responses go only to the owner; addr_ok is only meaningful while a request
    // is being issued, so a stray one during the data phase is dropped.
    always_comb begin
        bus.iresp = '0;
        bus.dresp = '0;
        if (w_grantI) begin
            bus.iresp.addr_ok = w_issue && bus.mresp.addr_ok;
            bus.iresp.data_ok = bus.mresp.data_ok;
            bus.iresp.data    = bus.mresp.data;
        end
        if (w_grantD) begin
            bus.dresp.addr_ok = w_issue && bus.mresp.addr_ok;
            bus.dresp.data_ok = bus.mresp.data_ok;
            bus.dresp.data    = bus.mresp.data;
        end
    end

    // Next state: zero-wait completions fall straight back to IDLE, and the next
    // grant is only considered one cycle later.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_ADDR_I, S_ADDR_D: begin
                if (w_issue) begin
                    if (!bus.mresp.addr_ok) begin
                        w_nextState = w_grantD ? S_ADDR_D : S_ADDR_I;
                    end else if (!bus.mresp.data_ok) begin
                        w_nextState = w_grantD ? S_DATA_D : S_DATA_I;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            S_DATA_I, S_DATA_D: begin
                if (bus.mresp.data_ok) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

endmodule
